// File: rtl/bank_queue_ctrl.sv
// Bank queue sequencer: synchronizes and edge-detects the entry/exit photocells,
// tracks queue occupancy and registers the wait time looked up from the ROM.
module bank_queue_ctrl #(
  parameter int CNT_W       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_sensor,
  input  logic             exit_sensor,
  input  logic [1:0]       tellers,
  input  logic [CNT_W+1:0] rom_data,
  output logic [CNT_W+1:0] rom_addr,
  output logic [CNT_W-1:0] pcount,
  output logic             full,
  output logic             empty,
  output logic [CNT_W+1:0] wtime,
  output logic             reject
);

  localparam logic [CNT_W-1:0] CAP = {CNT_W{1'b1}};

  // Index 0 is the entry channel, index 1 the exit channel.
  logic [1:0] sens_in;
  logic [1:0] evt;

  assign sens_in = {exit_sensor, entry_sensor};

  for (genvar gi = 0; gi < 2; gi++) begin : gen_sens
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;
    logic                   hist_d;

    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], sens_in[gi]};
      hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q <= '0;
        hist_q <= 1'b0;
      end else begin
        sync_q <= sync_d;
        hist_q <= hist_d;
      end
    end

    // One pulse per rising edge of the synchronized beam signal.
    assign evt[gi] = sync_q[SYNC_STAGES-1] & ~hist_q;
  end

  logic [CNT_W-1:0] pcount_q, pcount_d;
  logic             reject_q, reject_d;
  logic [1:0]       tellers_q, tellers_d;
  logic [CNT_W+1:0] wtime_q, wtime_d;

  logic ent;
  logic ext;
  logic closed;
  logic is_full;
  logic is_empty;

  assign ent      = evt[0];
  assign ext      = evt[1];
  assign closed   = (tellers_q == 2'd0);
  assign is_full  = (pcount_q == CAP);
  assign is_empty = (pcount_q == '0);

  always_comb begin
    pcount_d  = pcount_q;
    reject_d  = 1'b0;
    tellers_d = tellers;
    wtime_d   = rom_data;
    unique case ({ent, ext})
      2'b10: begin
        if (is_full || closed) reject_d = 1'b1;
        else                   pcount_d = pcount_q + CNT_W'(1);
      end
      2'b01: begin
        if (!is_empty) pcount_d = pcount_q - CNT_W'(1);
      end
      2'b11: begin
        // A simultaneous exit frees the slot the entrant takes, even when full.
        if (is_empty) begin
          if (closed) reject_d = 1'b1;
          else        pcount_d = CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcount_q  <= '0;
      reject_q  <= 1'b0;
      tellers_q <= 2'd0;
      wtime_q   <= '0;
    end else begin
      pcount_q  <= pcount_d;
      reject_q  <= reject_d;
      tellers_q <= tellers_d;
      wtime_q   <= wtime_d;
    end
  end

  assign rom_addr = {tellers_q, pcount_q};
  assign pcount   = pcount_q;
  assign full     = is_full;
  assign empty    = is_empty;
  assign wtime    = wtime_q;
  assign reject   = reject_q;

endmodule

// File: tb/tb_bank_queue_ctrl.sv
// Bench for bank_queue_ctrl: an event-level occupancy model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_bank_queue_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       entry_sensor = 1'b0;
  logic       exit_sensor = 1'b0;
  logic [1:0] tellers = 2'd1;
  logic [4:0] rom_data;
  logic [4:0] rom_addr;
  logic [2:0] pcount;
  logic       full;
  logic       empty;
  logic [4:0] wtime;
  logic       reject;

  int checks = 0;
  int failures = 0;
  int rej_seen = 0;

  always #5 clk = ~clk;

  bank_queue_ctrl #(.CNT_W(3), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .entry_sensor(entry_sensor), .exit_sensor(exit_sensor),
    .tellers(tellers), .rom_data(rom_data), .rom_addr(rom_addr), .pcount(pcount),
    .full(full), .empty(empty), .wtime(wtime), .reject(reject)
  );

  // Wait-time ROM: 3 minutes per customer per teller, rounded up; closed bank reads 0.
  function automatic logic [4:0] rom_fn(input logic [1:0] t, input logic [2:0] c);
    int ti;
    int ci;
    ti = int'(t);
    ci = int'(c);
    if (ti == 0) return 5'd0;
    return 5'(3 * ((ci + ti - 1) / ti));
  endfunction

  assign rom_data = rom_fn(rom_addr[4:3], rom_addr[2:0]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an event fires two edges after the beam rising edge is sampled.
  int         m_cnt = 0;
  bit         m_rej = 1'b0;
  logic [4:0] m_wt = 5'd0;
  logic [1:0] m_tq = 2'd0;
  bit         eh [3] = '{0, 0, 0};
  bit         xh [3] = '{0, 0, 0};

  always @(posedge clk or negedge rst) begin
    bit ent;
    bit ext;
    bit closed;
    if (!rst) begin
      m_cnt = 0;
      m_rej = 1'b0;
      m_wt  = 5'd0;
      m_tq  = 2'd0;
      eh    = '{0, 0, 0};
      xh    = '{0, 0, 0};
    end else begin
      ent    = eh[1] && !eh[2];
      ext    = xh[1] && !xh[2];
      closed = (m_tq == 2'd0);
      m_wt   = rom_fn(m_tq, 3'(m_cnt));
      m_rej  = 1'b0;
      if (ent && !ext) begin
        if (m_cnt == 7 || closed) m_rej = 1'b1;
        else m_cnt = m_cnt + 1;
      end else if (!ent && ext) begin
        if (m_cnt > 0) m_cnt = m_cnt - 1;
      end else if (ent && ext) begin
        if (m_cnt == 0) begin
          if (closed) m_rej = 1'b1;
          else m_cnt = 1;
        end
      end
      eh[2] = eh[1]; eh[1] = eh[0]; eh[0] = entry_sensor;
      xh[2] = xh[1]; xh[1] = xh[0]; xh[0] = exit_sensor;
      m_tq  = tellers;
    end
  end

  always @(negedge clk) begin
    chk("pcount", 32'(pcount), 32'(m_cnt));
    chk("full", 32'(full), 32'(m_cnt == 7));
    chk("empty", 32'(empty), 32'(m_cnt == 0));
    chk("rom_addr", 32'(rom_addr), 32'({m_tq, 3'(m_cnt)}));
    chk("wtime", 32'(wtime), 32'(m_wt));
    chk("reject", 32'(reject), 32'(m_rej));
    if (reject === 1'b1) rej_seen++;
  end

  task automatic pulse(input bit en, input bit ex);
    entry_sensor = en;
    exit_sensor  = ex;
    repeat (4) @(negedge clk);
    entry_sensor = 1'b0;
    exit_sensor  = 1'b0;
    repeat (4) @(negedge clk);
    $display("pulse entry=%0d exit=%0d tellers=%0d -> pcount=%0d wtime=%0d rejects=%0d",
             en, ex, tellers, pcount, wtime, rej_seen);
  endtask

  initial begin
    int r0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_pcount", 32'(pcount), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_wtime", 32'(wtime), 32'd0);
    chk("rst_reject", 32'(reject), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_rom_addr", 32'(rom_addr), 32'b01000);
    chk("rel_wtime", 32'(wtime), 32'd0);
    repeat (2) @(negedge clk);

    // Fill to full with one teller
    r0 = rej_seen;
    for (int k = 1; k <= 8; k++) begin
      pulse(1'b1, 1'b0);
      chk("fill_pcount", 32'(pcount), 32'((k > 7) ? 7 : k));
      chk("fill_wtime", 32'(wtime), 32'(3 * ((k > 7) ? 7 : k)));
      if (k == 7) chk("fill_full", 32'(full), 32'd1);
      chk("fill_rejects", 32'(rej_seen - r0), 32'((k == 8) ? 1 : 0));
    end

    // Down to 5, then asynchronous reset mid-cycle
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    chk("pre_rst_pcount", 32'(pcount), 32'd5);
    #2 rst = 1'b0;
    #1;
    chk("async_pcount", 32'(pcount), 32'd0);
    chk("async_empty", 32'(empty), 32'd1);
    chk("async_wtime", 32'(wtime), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rel2_rom_addr", 32'(rom_addr), 32'b01000);
    chk("rel2_wtime", 32'(wtime), 32'd0);
    repeat (2) @(negedge clk);

    // Drain past empty with two tellers
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    tellers = 2'd2;
    repeat (4) @(negedge clk);
    r0 = rej_seen;
    for (int k = 1; k <= 3; k++) begin
      pulse(1'b0, 1'b1);
      chk("drain_pcount", 32'(pcount), 32'((k == 1) ? 1 : 0));
      chk("drain_wtime", 32'(wtime), 32'((k == 1) ? 3 : 0));
    end
    chk("drain_rejects", 32'(rej_seen - r0), 32'd0);

    // Simultaneous events at empty, then at full
    pulse(1'b1, 1'b1);
    chk("simul_empty", 32'(pcount), 32'd1);
    repeat (6) pulse(1'b1, 1'b0);
    chk("refill", 32'(pcount), 32'd7);
    r0 = rej_seen;
    pulse(1'b1, 1'b1);
    chk("simul_full", 32'(pcount), 32'd7);
    chk("simul_full_rej", 32'(rej_seen - r0), 32'd0);

    // Closed bank
    repeat (4) pulse(1'b0, 1'b1);
    tellers = 2'd0;
    repeat (4) @(negedge clk);
    r0 = rej_seen;
    pulse(1'b1, 1'b0);
    chk("closed_pcount", 32'(pcount), 32'd3);
    chk("closed_rej", 32'(rej_seen - r0), 32'd1);
    chk("closed_wtime", 32'(wtime), 32'd0);
    pulse(1'b0, 1'b1);
    chk("closed_exit", 32'(pcount), 32'd2);

    // Latency with a held sensor
    tellers = 2'd1;
    repeat (4) @(negedge clk);
    chk("held_wt0", 32'(wtime), 32'd6);
    entry_sensor = 1'b1;
    @(negedge clk);
    chk("held_e1", 32'(pcount), 32'd2);
    @(negedge clk);
    chk("held_e2", 32'(pcount), 32'd2);
    @(negedge clk);
    chk("held_e3", 32'(pcount), 32'd3);
    chk("held_e3_wt", 32'(wtime), 32'd6);
    @(negedge clk);
    chk("held_e4_wt", 32'(wtime), 32'd9);
    repeat (16) @(negedge clk);
    entry_sensor = 1'b0;
    repeat (4) @(negedge clk);
    chk("held_once", 32'(pcount), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bank_queue_ctrl.md
# bank_queue_ctrl

Queue sequencer for the bank waiting-line system. It synchronizes and edge-detects the entry and exit photocell sensors and maintains the occupancy count (0–7) with full/empty flags. It drives the 5-bit address of the wait-time ROM as {tellers, count} and registers the returned wait time for the display path. It sits between the raw sensor pins and the ROM/display logic.

## Interface
Parameters:
- CNT_W, 3, occupancy counter width; capacity = 2^CNT_W − 1 = 7.
- SYNC_STAGES, 2, synchronizer flops per sensor input (fixed at 2 for the timing below).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low; every register is cleared while rst = 0.
- entry_sensor  input  1  entry photocell, async level, 1 = beam broken.
- exit_sensor  input  1  exit photocell, async level, 1 = beam broken.
- tellers  input  2  number of open tellers (0–3); quasi-static.
- rom_data  input  5  wait time returned by the ROM for rom_addr (combinational ROM).
- rom_addr  output  5  {tellers_q, pcount}; combinational from registers.
- pcount  output  3  current queue occupancy.
- full  output  1  pcount == 7.
- empty  output  1  pcount == 0.
- wtime  output  5  registered wait time, in minutes.
- reject  output  1  one-cycle pulse when an entry event is dropped.

## Operation
- **Sensor path:** each sensor passes through 2 flops (s1, s2), then a history flop s3. The event pulse is s2 & ~s3, so one pulse per rising edge of the beam. A held-high sensor produces exactly one event.
- **tellers_q:** tellers is registered every cycle.
- **Bank closed:** tellers_q == 0 means closed.
- **Counter update, per cycle, with ent/ext = event pulses:**
  - ent only: if full or closed → no change, reject = 1. Otherwise pcount + 1.
  - ext only: if empty → no change (underflow ignored, no flag). Otherwise pcount − 1.
  - ent and ext together:
    - If empty and open → pcount + 1.
    - If empty and closed → no change, reject = 1.
    - Otherwise → pcount unchanged and reject = 0. This also applies when full: the customer leaving frees the slot the new customer takes.
  - neither: hold.
- **Flags:** full and empty are decoded combinationally from pcount. They are never both 1.
- **rom_addr:** {tellers_q, pcount}.
- **wtime:** wtime <= rom_data every cycle. The ROM returns 0 for addresses with tellers_q == 0.
- **No wrap-around:** pcount never passes 7→0 or 0→7.
- **Reset mid-operation:** all registers return to reset values immediately. An event pulse in flight is lost. A sensor still high at reset release produces one event after synchronization, because s3 = 0.

## Timing
- Reset values:
  - Outputs: pcount = 0, empty = 1, full = 0, wtime = 0, reject = 0, rom_addr = 0.
  - Internal: s1/s2/s3 = 0, tellers_q = 0.
- Sensor latency, with the sensor rising before clock edge E1:
  - E1: s1 captures the sensor.
  - E2: s2 captures it; the pulse is high for the E2–E3 cycle.
  - E3: pcount/full/empty update, and reject is asserted for the cycle after E3.
  - E4: wtime reflects the new address.
- tellers change: rom_addr follows after 1 edge; wtime follows after 2 edges.
- Back-to-back events: events one cycle apart are impossible per sensor, since each sensor needs a low cycle between events. Events two cycles apart are each counted.
- reject is a single-cycle pulse, registered, and never held.

## Test plan
- **Reset:** rst = 0 asynchronously mid-cycle with pcount = 5 → pcount = 0, empty = 1, wtime = 0 immediately. Release with tellers = 1 → rom_addr = 5'b01000 after 1 edge, wtime = 0.
- **Fill to full:** tellers = 1, 8 entry pulses (each high 4 cycles, low 4 cycles).
  - Pulses 1–7: pcount steps 1…7, with wtime tracking 3, 6, …, 21.
  - After pulse 7: full = 1.
  - Pulse 8: pcount stays 7 and reject pulses once.
- **Drain past empty:** from pcount = 2, tellers = 2, 3 exit pulses → pcount 1, 0, 0; wtime 3, 0, 0. No reject.
- **Simultaneous events:**
  - pcount = 7, entry and exit rising on the same edge → pcount stays 7, reject = 0.
  - Repeat at pcount = 0 → pcount = 1.
- **Closed bank:** tellers = 0, pcount = 3, entry pulse → pcount = 3, reject = 1, wtime = 0. An exit pulse then gives pcount = 2.
- **Latency and held sensor:** entry held high for 20 cycles → exactly one increment, at the 3rd edge after the rise. wtime updates at the 4th edge.
